// File: rtl/write_logic_pkt_writer.sv
// Write-side controller of the 4-line packet buffer: streams bytes into data RAM at {line,char},
// records each packet's last char in the tlast pointer array and tracks line occupancy.
module write_logic_pkt_writer #(
    parameter int D_WIDTH = 8,
    parameter int CHAR_W  = 11,
    parameter int LINE_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [D_WIDTH-1:0]       s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     data_we,
    output logic [LINE_W+CHAR_W-1:0] wr_ptr,
    output logic [D_WIDTH-1:0]       wr_data,
    output logic [LINE_W+CHAR_W-1:0] wr_ptr_rgs,
    output logic                     tlastarray_cs_rgs,
    output logic                     we_rgs,
    input  logic                     rd_line_release,
    output logic                     line_commit,
    output logic                     pkt_dropped,
    output logic [LINE_W:0]          lines_used
);
    localparam int              NUM_LINES  = 1 << LINE_W;
    localparam logic [LINE_W:0] LINES_FULL = NUM_LINES[LINE_W:0];
    localparam logic [CHAR_W-1:0] CHAR_MAX = {CHAR_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LINE = 2'd0,
        WRITE     = 2'd1,
        COMMIT    = 2'd2,
        DROP      = 2'd3
    } state_t;

    state_t                     state_r;
    logic [LINE_W-1:0]          line_r;
    logic [CHAR_W-1:0]          char_r;
    logic [LINE_W:0]            lines_used_r;
    logic                       tready_r;
    logic [LINE_W+CHAR_W-1:0]   wr_ptr_rgs_r;
    logic                       commit_pulse_r;

    logic                       beat_s;
    logic                       commit_s;
    logic                       release_s;
    logic [LINE_W:0]            lines_next_s;

    // Handshake decode and next occupancy; a release against an empty buffer is ignored.
    always_comb begin
        beat_s       = s_axis_tvalid && tready_r;
        commit_s     = (state_r == COMMIT);
        release_s    = rd_line_release && (lines_used_r != {(LINE_W+1){1'b0}});
        lines_next_s = lines_used_r;
        if (commit_s && !release_s) begin
            lines_next_s = lines_used_r + (LINE_W+1)'(1'b1);
        end else if (!commit_s && release_s) begin
            lines_next_s = lines_used_r - (LINE_W+1)'(1'b1);
        end else begin
            lines_next_s = lines_used_r;
        end
    end

    // Byte writes go straight to RAM in the accepting cycle; drops are flagged on the closing beat.
    assign s_axis_tready     = tready_r;
    assign data_we           = beat_s && (state_r == WRITE);
    assign wr_ptr            = {line_r, char_r};
    assign wr_data           = data_we ? s_axis_tdata : {D_WIDTH{1'b0}};
    assign pkt_dropped       = beat_s && (state_r == DROP) && s_axis_tlast;
    assign wr_ptr_rgs        = wr_ptr_rgs_r;
    assign tlastarray_cs_rgs = commit_pulse_r;
    assign we_rgs            = commit_pulse_r;
    assign line_commit       = commit_pulse_r;
    assign lines_used        = lines_used_r;

    // Packet FSM with registered ready and tlast-array write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= WAIT_LINE;
            line_r         <= {LINE_W{1'b0}};
            char_r         <= {CHAR_W{1'b0}};
            lines_used_r   <= {(LINE_W+1){1'b0}};
            tready_r       <= 1'b0;
            wr_ptr_rgs_r   <= {(LINE_W+CHAR_W){1'b0}};
            commit_pulse_r <= 1'b0;
        end else begin
            lines_used_r   <= lines_next_s;
            commit_pulse_r <= 1'b0;
            wr_ptr_rgs_r   <= {(LINE_W+CHAR_W){1'b0}};
            case (state_r)
                WAIT_LINE: begin
                    if (lines_used_r < LINES_FULL) begin
                        state_r  <= WRITE;
                        tready_r <= 1'b1;
                    end else begin
                        state_r  <= WAIT_LINE;
                        tready_r <= 1'b0;
                    end
                end
                WRITE: begin
                    if (beat_s) begin
                        if (s_axis_tlast) begin
                            state_r        <= COMMIT;
                            tready_r       <= 1'b0;
                            commit_pulse_r <= 1'b1;
                            wr_ptr_rgs_r   <= {line_r, char_r};
                        end else if (char_r == CHAR_MAX) begin
                            state_r <= DROP;
                        end else begin
                            char_r <= char_r + CHAR_W'(1'b1);
                        end
                    end
                end
                COMMIT: begin
                    line_r <= line_r + LINE_W'(1'b1);
                    char_r <= {CHAR_W{1'b0}};
                    if (lines_next_s < LINES_FULL) begin
                        state_r  <= WRITE;
                        tready_r <= 1'b1;
                    end else begin
                        state_r  <= WAIT_LINE;
                        tready_r <= 1'b0;
                    end
                end
                DROP: begin
                    // Oversize packet: swallow bytes until tlast, then restart the same line.
                    if (beat_s && s_axis_tlast) begin
                        char_r  <= {CHAR_W{1'b0}};
                        state_r <= WRITE;
                    end
                end
                default: begin
                    state_r  <= WAIT_LINE;
                    tready_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_write_logic_pkt_writer.sv
// Bench for write_logic_pkt_writer: packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed addresses and counts.
module tb_write_logic_pkt_writer;
    logic        clk;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        data_we;
    logic [12:0] wr_ptr;
    logic [7:0]  wr_data;
    logic [12:0] wr_ptr_rgs;
    logic        tlastarray_cs_rgs;
    logic        we_rgs;
    logic        rd_line_release;
    logic        line_commit;
    logic        pkt_dropped;
    logic [2:0]  lines_used;

    write_logic_pkt_writer dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .data_we(data_we), .wr_ptr(wr_ptr), .wr_data(wr_data),
        .wr_ptr_rgs(wr_ptr_rgs), .tlastarray_cs_rgs(tlastarray_cs_rgs), .we_rgs(we_rgs),
        .rd_line_release(rd_line_release), .line_commit(line_commit), .pkt_dropped(pkt_dropped),
        .lines_used(lines_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: packet position, line index, occupancy, pending-commit bubble.
    bit  m_ready, m_bubble;
    int  m_occ, m_line, m_len, m_last;
    int  m_writes = 0, d_writes = 0, drops = 0;
    logic [7:0]  exp_ram [0:8191];
    logic [7:0]  dut_ram [0:8191];
    int          exp_tl [0:3];
    int          dut_tl [0:3];
    int          wq[$];
    int          cq[$];
    bit          auto_rel = 1'b0;

    always @(negedge clk) begin
        bit beat, e_we, n_ready, n_bubble, rel, closes;
        int n_occ;
        if (rst) begin
            chk("reset_outputs",
                {s_axis_tready, data_we, we_rgs, tlastarray_cs_rgs, line_commit, pkt_dropped},
                0);
            chk("reset_wr_ptr", wr_ptr, 0);
            chk("reset_lines_used", lines_used, 0);
            m_ready = 1'b0; m_bubble = 1'b0; m_occ = 0; m_line = 0; m_len = 0; m_last = 0;
        end else begin
            beat   = s_axis_tvalid && m_ready;
            e_we   = beat && (m_len < 2048);
            closes = beat && s_axis_tlast && (m_len < 2048);
            chk("tready", s_axis_tready, m_ready);
            chk("data_we", data_we, e_we);
            if (e_we) begin
                chk("wr_ptr", wr_ptr, m_line * 2048 + m_len);
                chk("wr_data", wr_data, s_axis_tdata);
                exp_ram[m_line * 2048 + m_len] = s_axis_tdata;
                m_writes++;
            end
            if (data_we) begin
                dut_ram[wr_ptr] = wr_data;
                wq.push_back(int'(wr_ptr));
                d_writes++;
            end
            chk("we_rgs", we_rgs, m_bubble);
            chk("line_commit", line_commit, m_bubble);
            chk("tlastarray_cs", tlastarray_cs_rgs, m_bubble);
            if (m_bubble) begin
                chk("wr_ptr_rgs", wr_ptr_rgs, m_line * 2048 + m_last);
                exp_tl[m_line] = m_last;
            end
            if (we_rgs) begin
                dut_tl[wr_ptr_rgs[12:11]] = int'(wr_ptr_rgs[10:0]);
                cq.push_back(int'(wr_ptr_rgs));
            end
            chk("pkt_dropped", pkt_dropped, beat && s_axis_tlast && (m_len >= 2048));
            if (pkt_dropped) drops++;
            chk("lines_used", lines_used, m_occ);

            rel   = rd_line_release && (m_occ > 0);
            n_occ = m_occ + (m_bubble ? 1 : 0) - (rel ? 1 : 0);
            if (m_bubble) begin
                n_ready = (n_occ < 4);
                m_line  = (m_line + 1) % 4;
            end else if (!m_ready) begin
                n_ready = (m_occ < 4);
            end else begin
                n_ready = !closes;
            end
            n_bubble = closes;
            if (beat) begin
                if (s_axis_tlast) begin
                    if (m_len < 2048) m_last = m_len;
                    m_len = 0;
                end else begin
                    m_len++;
                end
            end
            m_occ = n_occ; m_ready = n_ready; m_bubble = n_bubble;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_line_release = auto_rel ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic send(input int len, input int gap, input bit do_last, input bit rnd,
                        input logic [7:0] d0);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < len && guard < 20000) begin
            s_axis_tvalid = ($urandom_range(0, 99) >= gap);
            s_axis_tdata  = rnd ? 8'($urandom) : d0 + 8'(i);
            s_axis_tlast  = do_last && (i == len - 1);
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            tick();
            if (acc) i++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (i < len) begin
            failures++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", i, len);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        rd_line_release = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_lines_used", lines_used, 0);
        tick();
        rst = 1'b0;
        wq.delete();
        cq.delete();
        drops = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, bad;
        for (int a = 0; a < 8192; a++) begin
            exp_ram[a] = 8'h00;
            dut_ram[a] = 8'h00;
        end
        for (int k = 0; k < 4; k++) begin
            exp_tl[k] = 0;
            dut_tl[k] = 0;
        end
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
        rd_line_release = 1'b0;

        // 3-byte packet, then next packet on line 1
        do_reset();
        send(3, 0, 1'b1, 1'b0, 8'hA1);
        tick();
        @(negedge clk);
        chk("t1_lines_used", lines_used, 1);
        chk("t1_nwrites", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("t1_addr0", wq[0], 13'h0000);
            chk("t1_addr1", wq[1], 13'h0001);
            chk("t1_addr2", wq[2], 13'h0002);
        end
        chk("t1_commit_ptr", (cq.size() > 0) ? cq[$] : -1, 13'h0002);
        chk("t1_dram_a3", dut_ram[2], 8'hA3);
        tick();
        send(1, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t1_next_pkt", (wq.size() > 0) ? wq[$] : -1, 13'h0800);
        tick();

        // fill all four lines, then one release
        do_reset();
        repeat (4) send(1, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t2_full", lines_used, 4);
        chk("t2_tready_full", s_axis_tready, 0);
        chk("t2_ncommits", cq.size(), 4);
        if (cq.size() == 4) begin
            chk("t2_rgs0", cq[0], 13'h0000);
            chk("t2_rgs1", cq[1], 13'h0800);
            chk("t2_rgs2", cq[2], 13'h1000);
            chk("t2_rgs3", cq[3], 13'h1800);
        end
        tick();
        rd_line_release = 1'b1;
        tick();
        @(negedge clk);
        chk("t2_after_rel", lines_used, 3);
        chk("t2_tready_lag", s_axis_tready, 0);
        tick();
        @(negedge clk);
        chk("t2_tready_back", s_axis_tready, 1);
        tick();
        send(1, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t2_wrap_addr", (wq.size() > 0) ? wq[$] : -1, 13'h0000);
        tick();

        // exact-line packet commits; one byte longer drops
        do_reset();
        send(2048, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t3_full_line_ptr", (cq.size() > 0) ? cq[$] : -1, 13'h07FF);
        chk("t3_no_drop", drops, 0);
        tick();
        n0 = wq.size();
        send(2050, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t3_dropped", drops, 1);
        chk("t3_no_commit", cq.size(), 1);
        chk("t3_drop_writes", wq.size() - n0, 2048);
        tick();
        send(1, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t3_restart", (wq.size() > 0) ? wq[$] : -1, 13'h0800);
        tick();

        // release at empty, release coinciding with commit
        do_reset();
        rd_line_release = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_empty_rel", lines_used, 0);
        tick();
        send(1, 0, 1'b1, 1'b1, 8'h00);
        send(1, 0, 1'b1, 1'b1, 8'h00);
        send(1, 0, 1'b1, 1'b1, 8'h00);
        rd_line_release = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_commit_rel", lines_used, 2);
        tick();

        // reset in the middle of a packet
        do_reset();
        send(5, 0, 1'b0, 1'b1, 8'h00);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h55;
        #1 rst = 1'b1;
        #1;
        chk("t5_data_we", data_we, 0);
        chk("t5_tready", s_axis_tready, 0);
        chk("t5_wr_ptr", wr_ptr, 0);
        chk("t5_we_rgs", we_rgs, 0);
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("t5_no_commit", cq.size(), 0);
        wq.delete();
        send(3, 0, 1'b1, 1'b1, 8'h00);
        tick();
        @(negedge clk);
        chk("t5_restart", (wq.size() > 0) ? wq[0] : -1, 13'h0000);
        chk("t5_commit_ptr", (cq.size() > 0) ? cq[$] : -1, 13'h0002);
        tick();

        // random gaps and releases over 20 packets
        do_reset();
        auto_rel = 1'b1;
        for (int p = 0; p < 20; p++) begin
            send($urandom_range(1, 48), 50, 1'b1, 1'b1, 8'h00);
        end
        repeat (20) tick();
        auto_rel = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t6_commits", cq.size(), 20);
        bad = 0;
        for (int a = 0; a < 8192; a++) begin
            if (exp_ram[a] !== dut_ram[a]) bad++;
        end
        chk("t6_ram_mismatches", bad, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6_tlast_array_%0d", k), dut_tl[k], exp_tl[k]);
        end
        chk("t6_write_count", d_writes, m_writes);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
